// File: rtl/counter_down_timer_if.sv
// Control/status bundle for the loadable down-counting timer.
// The controller side drives the master modport and the timer uses the slave modport.
interface counter_down_timer_if #(
    parameter int CNT_WIDTH = 3
);
    logic [CNT_WIDTH-1:0] load_val;
    logic                 start;
    logic                 auto_reload;
    logic                 pause;
    logic                 abort;
    logic [CNT_WIDTH-1:0] counter;
    logic                 busy;
    logic                 tc;
    logic                 done;

    modport master (
        output load_val, start, auto_reload, pause, abort,
        input  counter, busy, tc, done
    );

    modport slave (
        input  load_val, start, auto_reload, pause, abort,
        output counter, busy, tc, done
    );
endinterface

// File: rtl/counter_down_timer.sv
// Loadable down-counting timer with a one-cycle terminal-count pulse.
// In one-shot mode it parks in DONE; in periodic mode it reloads the captured value.
module counter_down_timer #(
    parameter int CNT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_down_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] counter_q, counter_d;
    logic [CNT_WIDTH-1:0] reloadVal_q, reloadVal_d;
    logic                 autoReload_q, autoReload_d;
    logic                 busy_q, busy_d;
    logic                 tc_q, tc_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        reloadVal_d  = reloadVal_q;
        autoReload_d = autoReload_q;
        done_d       = done_q;
        tc_d         = 1'b0;

        if (bus.abort) begin
            state_d   = IDLE;
            counter_d = '0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // done is re-asserted here so a zero-length load shows done one cycle after its tc
                    if (state_q == DONE) done_d = 1'b1;
                    if (bus.start) begin
                        reloadVal_d  = bus.load_val;
                        autoReload_d = bus.auto_reload;
                        counter_d    = bus.load_val;
                        done_d       = 1'b0;
                        if (bus.load_val != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (counter_q > CNT_WIDTH'(1)) begin
                        if (bus.pause) state_d = PAUSE;
                        else           counter_d = counter_q - CNT_WIDTH'(1);
                    end else if (counter_q == CNT_WIDTH'(1)) begin
                        counter_d = '0;
                        tc_d      = 1'b1;
                    end else if (autoReload_q) begin
                        counter_d = reloadVal_q;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!bus.pause) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            reloadVal_q  <= '0;
            autoReload_q <= 1'b0;
            busy_q       <= 1'b0;
            tc_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            reloadVal_q  <= reloadVal_d;
            autoReload_q <= autoReload_d;
            busy_q       <= busy_d;
            tc_q         <= tc_d;
            done_q       <= done_d;
        end
    end

    assign bus.counter = counter_q;
    assign bus.busy    = busy_q;
    assign bus.tc      = tc_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_counter_down_timer.sv
// Directed bench for counter_down_timer: each step queues the outputs expected after the
// next clock edge, and they are popped and compared one cycle later.
module tb_counter_down_timer;
    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         tc;
        logic         done;
    } obs_t;

    logic  clk = 1'b0;
    logic  reset;
    obs_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    counter_down_timer_if #(.CNT_WIDTH(W)) bus ();

    counter_down_timer #(.CNT_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic pushExpected(input string tag, input int cnt, input bit busy,
                                input bit tc, input bit done);
        obs_t e;
        e.cnt  = W'(cnt);
        e.busy = busy;
        e.tc   = tc;
        e.done = done;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        obs_t  obs;
        obs_t  exp;
        string tag;
        obs = {bus.counter, bus.busy, bus.tc, bus.done};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed cnt=%0d busy=%0b tc=%0b done=%0b expected queued entry",
                   obs.cnt, obs.busy, obs.tc, obs.done);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("[TB] FAIL %s observed cnt=%0d busy=%0b tc=%0b done=%0b expected cnt=%0d busy=%0b tc=%0b done=%0b",
                       tag, obs.cnt, obs.busy, obs.tc, obs.done, exp.cnt, exp.busy, exp.tc, exp.done);
            end
        end
    endtask

    // Drive inputs on the falling edge, then check the registered outputs just after the rising edge.
    task automatic applyStimulus(input string tag, input bit st, input int lv, input bit ar,
                                 input bit pa, input bit ab, input int cnt, input bit busy,
                                 input bit tc, input bit done);
        @(negedge clk);
        bus.start       = st;
        bus.load_val    = W'(lv);
        bus.auto_reload = ar;
        bus.pause       = pa;
        bus.abort       = ab;
        pushExpected(tag, cnt, busy, tc, done);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.load_val    = '0;
        bus.auto_reload = 1'b0;
        bus.pause       = 1'b0;
        bus.abort       = 1'b0;
        #3;
        pushExpected("reset_state", 0, 0, 0, 0);
        checkOutput();
        @(negedge clk);
        reset = 1'b0;

        // One-shot from 5
        applyStimulus("os_load5",  1, 5, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("os_cnt4",   0, 0, 0, 0, 0, 4, 1, 0, 0);
        applyStimulus("os_cnt3",   0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("os_cnt2",   0, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("os_cnt1",   0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("os_tc",     0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("os_done",   0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("os_hold",   0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Periodic with period 4
        applyStimulus("per_load3", 1, 3, 1, 0, 0, 3, 1, 0, 0);
        applyStimulus("per_c2",    0, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("per_c1",    0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("per_tc1",   0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("per_rld",   0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("per_c2b",   0, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("per_c1b",   0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("per_tc2",   0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("per_rld2",  0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("per_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Pause at 4 for three cycles, then pause during the terminal cycle
        applyStimulus("pz_load6",  1, 6, 0, 0, 0, 6, 1, 0, 0);
        applyStimulus("pz_c5",     0, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("pz_c4",     0, 0, 0, 0, 0, 4, 1, 0, 0);
        applyStimulus("pz_hold1",  0, 0, 0, 1, 0, 4, 1, 0, 0);
        applyStimulus("pz_hold2",  0, 0, 0, 1, 0, 4, 1, 0, 0);
        applyStimulus("pz_hold3",  0, 0, 0, 1, 0, 4, 1, 0, 0);
        applyStimulus("pz_resume", 0, 0, 0, 0, 0, 4, 1, 0, 0);
        applyStimulus("pz_c3",     0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("pz_c2",     0, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("pz_c1",     0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("pz_tc",     0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("pz_tcpause",0, 0, 0, 1, 0, 0, 0, 0, 1);

        // Zero load: immediate DONE, one tc, no reload
        applyStimulus("z_load0",   1, 0, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus("z_done",    0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("z_hold",    0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Full-scale load of 7
        applyStimulus("max_load7", 1, 7, 0, 0, 0, 7, 1, 0, 0);
        for (int i = 6; i >= 1; i--)
            applyStimulus($sformatf("max_c%0d", i), 0, 0, 0, 0, 0, i, 1, 0, 0);
        applyStimulus("max_tc",    0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("max_done",  0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Period-2 reload; changed load_val/auto_reload inputs must not matter
        applyStimulus("p2_load1",  1, 1, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus("p2_tc1",    0, 5, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("p2_rld1",   0, 5, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("p2_tc2",    0, 5, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("p2_rld2",   0, 5, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("p2_tc3",    0, 5, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("p2_abort",  0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Restart attempt mid-count is ignored
        applyStimulus("rs_load5",  1, 5, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("rs_c4",     0, 0, 0, 0, 0, 4, 1, 0, 0);
        applyStimulus("rs_c3",     0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("rs_c2",     0, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("rs_ignore", 1, 7, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus("rs_tc",     0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("rs_done",   0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Abort at 3 gives no tc; start together with abort loses
        applyStimulus("ab_load4",  1, 4, 0, 0, 0, 4, 1, 0, 0);
        applyStimulus("ab_c3",     0, 0, 0, 0, 0, 3, 1, 0, 0);
        applyStimulus("ab_abort",  0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("ab_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("ab_both",   1, 6, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("ab_after",  0, 6, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset at counter 4, between edges
        applyStimulus("ar_load6",  1, 6, 0, 0, 0, 6, 1, 0, 0);
        applyStimulus("ar_c5",     0, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("ar_c4",     0, 0, 0, 0, 0, 4, 1, 0, 0);
        #2;
        reset = 1'b1;
        pushExpected("ar_async", 0, 0, 0, 0);
        #1;
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("ar_quiet1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("ar_quiet2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("ar_load2",  1, 2, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus("ar_c1",     0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("ar_tc",     0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("ar_done",   0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
